// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit for the integer pipeline.
// Multiply waits MUL_CYCLES; divide is restoring, one quotient bit per cycle.
module mul_div_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cancel,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic             whi,
   output logic             wlo,
   output logic [WIDTH-1:0] wHiData,
   output logic [WIDTH-1:0] wLoData,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             uns_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             dz_q;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] out_hi;
   logic [WIDTH-1:0] out_lo;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   rem_nx;
   logic [WIDTH-1:0]   quo_nx;
   logic               q_neg;
   logic               r_neg;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic               mul_last;
   logic               div_last;

   always_comb begin
      abs_a = (!op[0] && opa[WIDTH-1]) ? -opa : opa;
      abs_b = (!op[0] && opb[WIDTH-1]) ? -opb : opb;
   end

   // Sign/zero extension to 2*WIDTH makes one truncated product serve both.
   always_comb begin
      ext_a = uns_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
      ext_b = uns_q ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod  = ext_a * ext_b;
   end

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nx  = {quo[WIDTH-2:0], ~trial[WIDTH]};
      q_neg   = !uns_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      r_neg   = !uns_q && a_q[WIDTH-1];
      q_fix   = q_neg ? -quo_nx : quo_nx;
      r_fix   = r_neg ? -rem_nx : rem_nx;
   end

   assign mul_last = (cnt == CW'(MUL_CYCLES - 1));
   assign div_last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         uns_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         dz_q   <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
         out_hi <= '0;
         out_lo <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !cancel) begin
                  uns_q <= op[0];
                  a_q   <= opa;
                  b_q   <= opb;
                  rem   <= '0;
                  quo   <= abs_a;
                  dvs   <= abs_b;
                  cnt   <= '0;
                  state <= op[1] ? DIV : MUL;
               end
            end
            MUL: begin
               if (cancel) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (mul_last) begin
                  state  <= DONE;
                  dz_q   <= 1'b0;
                  res_hi <= prod[2*WIDTH-1:WIDTH];
                  res_lo <= prod[WIDTH-1:0];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DIV: begin
               if (cancel) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (dvs == '0) begin
                  state  <= DONE;
                  dz_q   <= 1'b1;
                  res_hi <= a_q;
                  res_lo <= '1;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  if (div_last) begin
                     state  <= DONE;
                     dz_q   <= 1'b0;
                     res_hi <= r_fix;
                     res_lo <= q_fix;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
               if (!cancel) begin
                  out_hi <= res_hi;
                  out_lo <= res_lo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A cancel landing on DONE must hide the fresh result, so it is muxed in.
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE) && !cancel;
      whi       = done;
      wlo       = done;
      div_zero  = done && dz_q;
      wHiData   = done ? res_hi : out_hi;
      wLoData   = done ? res_lo : out_lo;
      stall_req = (start && !cancel) || (busy && !done);
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_mul_div_unit;

   localparam int W  = 32;
   localparam int MC = 4;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           t0;
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = '0;
   logic [W-1:0] opa = '0;
   logic [W-1:0] opb = '0;
   logic         cancel = 1'b0;
   logic         busy;
   logic         stall_req;
   logic         done;
   logic         whi;
   logic         wlo;
   logic [W-1:0] wHiData;
   logic [W-1:0] wLoData;
   logic         div_zero;

   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   exp_t         sbq[$];
   exp_t         me;
   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;

   mul_div_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .op(op),
      .opa(opa),
      .opb(opb),
      .cancel(cancel),
      .busy(busy),
      .stall_req(stall_req),
      .done(done),
      .whi(whi),
      .wlo(wlo),
      .wHiData(wHiData),
      .wLoData(wLoData),
      .div_zero(div_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural rules.
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      longint p, sa, sb, q, r;
      longint unsigned ua, ub, up;
      e.dz = 1'b0;
      e.t0 = 0;
      if (!o[1]) begin
         if (o[0]) begin
            ua = {32'b0, a};
            ub = {32'b0, b};
            up = ua * ub;
            e.hi = up[63:32];
            e.lo = up[31:0];
         end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         e.lat = MC + 1;
      end else if (b == 0) begin
         e.hi = a;
         e.lo = '1;
         e.dz = 1'b1;
         e.lat = 2;
      end else if (o[0]) begin
         e.hi = a % b;
         e.lo = a / b;
         e.lat = W + 1;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = sa / sb;
         r = sa % sb;
         e.hi = r[31:0];
         e.lo = q[31:0];
         e.lat = W + 1;
      end
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom % 6)
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'd1;
         4: return W'($urandom % 200);
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      exp_t e;
      op = o;
      opa = a;
      opb = b;
      start = 1'b1;
      if (push) begin
         e = model(o, a, b);
         e.t0 = cyc;
         sbq.push_back(e);
      end
      tick();
      start = 1'b0;
      op = 2'($urandom);
      opa = $urandom;
      opb = $urandom;
   endtask

   // Inputs churn (including stray starts) while busy; none may launch.
   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         tick();
         if (!busy) begin
            start = 1'b0;
            chk("hold_hi", wHiData, last_hi);
            chk("hold_lo", wLoData, last_lo);
            return;
         end
         start = 1'($urandom);
         op = 2'($urandom);
         opa = $urandom;
         opb = $urandom;
      end
      start = 1'b0;
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      launch(o, a, b, 1'b1);
      wait_idle();
   endtask

   task automatic all_zero(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_whi"}, whi, 0);
      chk({nm, "_wlo"}, wlo, 0);
      chk({nm, "_dz"}, div_zero, 0);
      chk({nm, "_hi"}, wHiData, 0);
      chk({nm, "_lo"}, wLoData, 0);
      chk({nm, "_stall"}, stall_req, 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("whi_eq_done", whi, done);
         chk("wlo_eq_done", wlo, done);
         chk("stall_req", stall_req, (start & ~cancel) | (busy & ~done));
         if (done) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
               me = sbq.pop_front();
               chk("hi", wHiData, me.hi);
               chk("lo", wLoData, me.lo);
               chk("div_zero", div_zero, me.dz);
               chk("latency", cyc - me.t0, me.lat);
               last_hi = me.hi;
               last_lo = me.lo;
            end
         end else if (sbq.size() > 0 && cyc - sbq[0].t0 >= sbq[0].lat) begin
            total++;
            bad++;
            $display("FAIL missing_done: got done=0 expected done=1 (cycle %0d)", cyc);
            me = sbq.pop_front();
         end
      end
   end

   initial begin
      repeat (3) tick();
      all_zero("reset");
      rst = 1'b1;

      issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      issue(2'b11, 32'h0000_0064, 32'h0000_0007);
      issue(2'b11, 32'h0000_0064, 32'h0000_0000);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

      // Cancel on divide cycle 10, then an immediate relaunch.
      launch(2'b10, 32'h1234_5678, 32'h0000_0003, 1'b0);
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("cancel_div_busy", busy, 0);
      chk("cancel_div_hi", wHiData, last_hi);
      chk("cancel_div_lo", wLoData, last_lo);
      issue(2'b00, 32'd7, 32'd9);

      // Cancel landing exactly on the done cycle.
      launch(2'b01, 32'h1111_1111, 32'h0000_0003, 1'b0);
      repeat (MC) tick();
      cancel = 1'b1;
      #1;
      chk("cancel_done_done", done, 0);
      chk("cancel_done_dz", div_zero, 0);
      chk("cancel_done_hi", wHiData, last_hi);
      chk("cancel_done_lo", wLoData, last_lo);
      tick();
      cancel = 1'b0;
      chk("cancel_done_busy", busy, 0);

      // Cancel beats start in IDLE.
      start = 1'b1;
      cancel = 1'b1;
      tick();
      start = 1'b0;
      cancel = 1'b0;
      chk("cancel_start_busy", busy, 0);
      repeat (8) tick();

      // Reset during multiply cycle 2.
      issue(2'b00, 32'h0001_0000, 32'h0003_0000);
      launch(2'b00, 32'h0001_2345, 32'h0000_0777, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      all_zero("async_rst");
      last_hi = '0;
      last_lo = '0;
      tick();
      tick();
      rst = 1'b1;
      issue(2'b11, 32'd1000, 32'd33);

      for (int n = 0; n < 40; n++) begin
         issue(2'($urandom), pick(), pick());
         repeat ($urandom % 3) tick();
      end

      repeat (4) tick();
      chk("queue_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
